// File: rtl/button_pulser.sv
// Turns five debounced button levels into registered one-cycle press pulses.
// Define BUTTON_REPEAT_EN to build the U/D auto-repeat engine timed from i_clk1KHz.
module button_pulser #(
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clk1KHz,
    input  logic i_B_U,
    input  logic i_B_D,
    input  logic i_B_L,
    input  logic i_B_R,
    input  logic i_B_C,
    output logic o_p_U,
    output logic o_p_D,
    output logic o_p_L,
    output logic o_p_R,
    output logic o_p_C,
    output logic o_any
);

    if (HOLD_MS < 1 || HOLD_MS > 1023) begin : g_bad_hold
        $error("HOLD_MS must be in 1..1023");
    end
    if (REPEAT_MS < 1 || REPEAT_MS > 1023) begin : g_bad_repeat
        $error("REPEAT_MS must be in 1..1023");
    end

    // Bit order everywhere: 0=U, 1=D, 2=L, 3=R, 4=C
    logic [4:0] btn;
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;
    logic [4:0] prev_q;
    logic [4:0] rise;
    logic [4:0] rep;
    logic [4:0] pulse_q;
    logic       any_q;

    assign btn  = {i_B_C, i_B_R, i_B_L, i_B_D, i_B_U};
    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= rise | rep;
            any_q   <= |(rise | rep);
        end
    end

    assign o_p_U = pulse_q[0];
    assign o_p_D = pulse_q[1];
    assign o_p_L = pulse_q[2];
    assign o_p_R = pulse_q[3];
    assign o_p_C = pulse_q[4];
    assign o_any = any_q;

`ifdef BUTTON_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StLock} state_e;

    localparam logic [9:0] HoldLast   = 10'(HOLD_MS - 1);
    localparam logic [9:0] RepeatLast = 10'(REPEAT_MS - 1);

    state_e     state_q;
    logic [9:0] cnt_q;
    logic       owner_q;
    logic       k_sync1_q;
    logic       k_sync2_q;
    logic       k_prev_q;
    logic       ms_tick;
    logic       own_held;
    logic       other_held;
    logic       cnt_hit;
    logic       fire;

    assign ms_tick    = k_sync2_q & ~k_prev_q;
    assign own_held   = owner_q ? sync2_q[1] : sync2_q[0];
    assign other_held = owner_q ? sync2_q[0] : sync2_q[1];

    always_comb begin
        cnt_hit = 1'b0;
        case (state_q)
            StDelay:  cnt_hit = (cnt_q == HoldLast);
            StRepeat: cnt_hit = (cnt_q == RepeatLast);
            default:  cnt_hit = 1'b0;
        endcase
        // Release and lock take priority over a tick landing in the same cycle
        fire   = ms_tick & own_held & ~other_held & cnt_hit;
        rep    = '0;
        rep[0] = fire & ~owner_q;
        rep[1] = fire & owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_sync1_q <= 1'b0;
            k_sync2_q <= 1'b0;
            k_prev_q  <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
        end else begin
            k_sync1_q <= i_clk1KHz;
            k_sync2_q <= k_sync1_q;
            k_prev_q  <= k_sync2_q;
            case (state_q)
                StIdle: begin
                    if ((rise[0] | rise[1]) && (sync2_q[0] ^ sync2_q[1])) begin
                        state_q <= StDelay;
                        owner_q <= sync2_q[1];
                        cnt_q   <= '0;
                    end
                end
                StDelay, StRepeat: begin
                    if (!own_held) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (other_held) begin
                        state_q <= StLock;
                        cnt_q   <= '0;
                    end else if (ms_tick) begin
                        if (cnt_hit) begin
                            state_q <= StRepeat;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                end
                StLock: begin
                    if (!sync2_q[0] && !sync2_q[1]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    logic unused_clk1k;

    assign unused_clk1k = i_clk1KHz;
    assign rep          = '0;
`endif

endmodule

// File: tb/tb_button_pulser.sv
// Randomised scoreboard bench for button_pulser; a level-history model predicts every pulse.
module tb_button_pulser;

    localparam int unsigned Hold   = 4;
    localparam int unsigned Repeat = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic kclk;
    logic bu, bd, bl, br, bc;
    logic o_p_U, o_p_D, o_p_L, o_p_R, o_p_C, o_any;

    button_pulser #(
        .HOLD_MS   (Hold),
        .REPEAT_MS (Repeat)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clk1KHz (kclk),
        .i_B_U     (bu),
        .i_B_D     (bd),
        .i_B_L     (bl),
        .i_B_R     (br),
        .i_B_C     (bc),
        .o_p_U     (o_p_U),
        .o_p_D     (o_p_D),
        .o_p_L     (o_p_L),
        .o_p_R     (o_p_R),
        .o_p_C     (o_p_C),
        .o_any     (o_any)
    );

    always #5 clk = ~clk;

    // Fast stand-in for the 1 kHz wave; transitions never coincide with a rising clk edge
    initial begin
        kclk = 1'b0;
        #2;
        forever #40 kclk = ~kclk;
    end

    typedef struct {
        int unsigned edge_idx;
        logic [4:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    logic [5:0]  hist[$];
    int unsigned edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [5:0] samp(int j);
        if (j < 0 || j >= hist.size()) return 6'd0;
        return hist[j];
    endfunction

    // Reference: pulse after edge a when the level seen two edges earlier rose
    logic [5:0] cur, old;
    logic [4:0] press, rpt;
`ifdef BUTTON_REPEAT_EN
    int          mode;     // 0 none, 1 counting a lone hold, 2 both pressed
    logic        own;
    int unsigned n_ticks, target;
    logic        su, sd, tick, held, other;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            exp_q.delete();
            edge_n = 0;
`ifdef BUTTON_REPEAT_EN
            mode = 0;
`endif
        end else begin
            edge_n++;
            hist.push_back({kclk, bc, br, bl, bd, bu});
            cur   = samp(int'(edge_n) - 3);
            old   = samp(int'(edge_n) - 4);
            press = cur[4:0] & ~old[4:0];
            rpt   = '0;
`ifdef BUTTON_REPEAT_EN
            su   = cur[0];
            sd   = cur[1];
            tick = cur[5] & ~old[5];
            case (mode)
                0: if ((press[0] | press[1]) && (su ^ sd)) begin
                    mode = 1; own = sd; n_ticks = 0; target = Hold;
                end
                1: begin
                    held  = own ? sd : su;
                    other = own ? su : sd;
                    if (!held) mode = 0;
                    else if (other) mode = 2;
                    else if (tick) begin
                        n_ticks++;
                        if (n_ticks == target) begin
                            if (own) rpt[1] = 1'b1;
                            else rpt[0] = 1'b1;
                            n_ticks = 0;
                            target  = Repeat;
                        end
                    end
                end
                default: if (!su && !sd) mode = 0;
            endcase
`endif
            if ((press | rpt) != 5'd0) exp_q.push_back('{edge_n, press | rpt});
        end
    end

    logic [4:0] mon_got;
    exp_t       mon_e;

    always @(negedge clk) begin
        mon_got = {o_p_C, o_p_R, o_p_L, o_p_D, o_p_U};
        if (!reset_n) begin
            checks++;
            if (mon_got != 5'd0 || o_any !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got pulses=%b any=%b, required 00000/0", mon_got, o_any);
            end
        end else if (mon_got != 5'd0 || o_any !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: edge %0d got %b any=%b, required none",
                         edge_n, mon_got, o_any);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.edge_idx != edge_n || mon_e.mask != mon_got || o_any !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse: edge %0d got %b any=%b, required edge %0d mask %b any=1",
                             edge_n, mon_got, o_any, mon_e.edge_idx, mon_e.mask);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_idx <= edge_n) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: edge %0d got none, required mask %b at edge %0d",
                     edge_n, exp_q[0].mask, exp_q[0].edge_idx);
            void'(exp_q.pop_front());
        end
    end

    task automatic drive(input logic [4:0] m, input int cycles);
        @(negedge clk);
        {bc, br, bl, bd, bu} = m;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [4:0] rmask;
    int         rlen;

    initial begin
        reset_n = 1'b0;
        {bc, br, bl, bd, bu} = 5'b00001;   // U already held when reset releases
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        drive(5'b00001, 20);
        drive(5'b00000, 10);
        drive(5'b00100, 10);               // short L press
        drive(5'b00000, 10);
        drive(5'b10011, 40);               // U, D, C together
        drive(5'b00000, 10);
        drive(5'b01000, 6);
        drive(5'b11000, 6);                // C joins while R held
        drive(5'b00000, 10);
`ifdef BUTTON_REPEAT_EN
        drive(5'b00001, 120);              // lone U hold: repeats
        drive(5'b00000, 10);
        drive(5'b00010, 20);
        drive(5'b00011, 80);               // U joins D: lock
        drive(5'b00000, 10);
        drive(5'b00010, 50);
`endif
        pulse_reset(3);                    // reset during a hold, level kept
        drive(5'b00010, 60);
        drive(5'b00000, 10);

        for (int i = 0; i < 250; i++) begin
            rmask = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rmask = 5'd0;
            rlen = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 90);
            if (i == 120) pulse_reset($urandom_range(1, 4));
            drive(rmask, rlen);
        end

        drive(5'b00000, 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
